decode_read_stage: RTL and testbench
====================================

Name: decode_read_stage

Overview:
Decode/operand-read stage of the 5-stage pipeline. It is the read-side counterpart of the writeback port into the register file.
- Decodes source registers from the F/D instruction and drives the regfile read ports.
- Applies same-cycle writeback write-through and $r0 forcing.
- Detects load-use hazards and honours downstream hold and branch flush.
- Registers the result into the D/X pipeline register, which feeds the execute stage.

Parameters:
DATA_W, 32, width of register data and PC
NOP_INSN, 32'h0000_0000, instruction word loaded into D/X on a bubble
CNT_W, 16, width of optional stall counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
fd_insn  in  32  instruction from F/D register
fd_pc  in  DATA_W  PC+1 of fd_insn
fd_valid  in  1  fd_insn is a real instruction
ctrl_readRegA  out  5  regfile read port A address (combinational)
ctrl_readRegB  out  5  regfile read port B address (combinational)
data_readRegA  in  DATA_W  regfile port A data, same cycle
data_readRegB  in  DATA_W  regfile port B data, same cycle
wb_writeEnable  in  1  writeback write enable, this cycle
wb_writeReg  in  5  writeback destination
wb_data  in  DATA_W  writeback data
hold  in  1  execute/multdiv busy; freeze D/X
flush  in  1  taken branch/jump resolved in X; squash fd_insn
dx_insn  out  32  D/X instruction
dx_pc  out  DATA_W  D/X PC
dx_a  out  DATA_W  operand A
dx_b  out  DATA_W  operand B
dx_valid  out  1  D/X holds a real instruction
stall_fd  out  1  hold PC and F/D this cycle (combinational)

Behaviour:
- Opcode is insn[31:27]. Field rd = [26:22], rs = [21:17], rt = [16:12].
- Read address selection:
  - R-type (00000): A = rs, B = rt.
  - sw (00111), bne (00010), blt (00110): A = rs, B = rd.
  - jr (00100): A = rd, B = 0.
  - bex (10110): A = 5'd30, B = 0.
  - All other opcodes: A = rs, B = 0.
- Operand value, per port:
  - Address 0: value is 0.
  - Otherwise, if wb_writeEnable and wb_writeReg == address: value is wb_data (write-through).
  - Otherwise: value is the regfile data.
- Load-use hazard: dx_valid, dx_insn opcode = 01000 (lw), dx rd != 0, and dx rd equals a nonzero source address actually used by fd_insn. A source is "used" if it is selected by the opcode table above and is not the hard-wired 0.
- Per-cycle priority, highest first:
  1. reset: all D/X outputs 0, dx_insn = NOP_INSN, dx_valid = 0; applied immediately, asynchronously.
  2. hold: D/X retains its value; stall_fd = 1; flush is ignored this cycle, and the flush source keeps flush asserted until hold drops.
  3. flush: D/X loads a bubble (NOP_INSN, pc 0, a/b 0, dx_valid 0); stall_fd = 0.
  4. load-use, with fd_valid: D/X loads a bubble; stall_fd = 1, so the same fd_insn is re-presented next cycle.
  5. normal: D/X loads fd_insn, fd_pc, the two operands, and fd_valid.
- fd_valid = 0 with no other event: a bubble is loaded, and load-use detection is suppressed.
- Latency is 1 cycle from F/D to D/X. Throughput is 1 instruction per cycle with no hazards.
- A load-use stall lasts exactly one cycle, because the lw then leaves D/X.
- Deasserting reset mid-operation: the first edge afterwards behaves as normal.

Optional Feature:
Macro DECODE_STALL_CNT_EN.
- Defined: adds output stall_count [CNT_W-1:0]. It increments by 1 on each clock edge where a load-use bubble is inserted, saturates at all-ones, and is 0 on reset. Hold and flush cycles are not counted.
- Undefined: no port and no counter logic; behaviour is otherwise identical.

Decomposition:
- Shared package pipeline_defs:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BNE, OP_BLT, OP_JR, OP_BEX, OP_JAL, OP_SETX);
  - REG_RSTATUS = 30, REG_RA = 31;
  - instruction field bit positions.
  These are shared with the writeback stage.
- One sub-module, decode_read_sel: combinational opcode → (ctrl_readRegA, ctrl_readRegB, useA, useB).
- The top level keeps the bypass muxes, hazard logic, and D/X register.

Test Plan:
1. Reset asserted mid-stream, between clock edges → dx_insn = NOP_INSN, dx_a = 0, dx_valid = 0 immediately, without waiting for an edge.
2. Regfile r1 = 5, r2 = 7; fd = add $3,$1,$2 → ctrl_readRegA = 1, ctrl_readRegB = 2; next edge dx_a = 5, dx_b = 7, dx_valid = 1.
3. Same cycle wb_writeEnable = 1, wb_writeReg = 1, wb_data = 0x99 → dx_a = 0x99. Repeat with wb_writeReg = 0 and fd reading $0 → dx_a = 0.
4. dx = lw $4,0($1); fd = add $5,$4,$1 → stall_fd = 1, next dx is a bubble. The following edge loads the add with dx_valid = 1. With fd = add $5,$6,$1 → no stall.
5. hold = 1 for 3 cycles, with flush = 1 in the second cycle → D/X unchanged for all 3 edges, stall_fd = 1. Then flush alone → bubble.
6. fd = bex → ctrl_readRegA = 30. fd = sw $7,4($2) → A = 2, B = 7. fd = jr $31 → A = 31.

Source files
------------

// File: rtl/pipeline_defs.sv
// Shared pipeline definitions: opcodes, special register numbers and
// instruction field positions used by the decode and writeback stages.
package pipeline_defs;

    // Opcode field values (insn[31:27])
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    // Architecturally special registers
    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam logic [4:0] REG_RSTATUS = 5'd30;
    localparam logic [4:0] REG_RA      = 5'd31;

    // Instruction field bit positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RD_HI  = 26;
    localparam int RD_LO  = 22;
    localparam int RS_HI  = 21;
    localparam int RS_LO  = 17;
    localparam int RT_HI  = 16;
    localparam int RT_LO  = 12;

endpackage

// File: rtl/decode_read_sel.sv
// Register-read address selection: maps an opcode and its register fields
// onto the two regfile read ports and flags which ports carry a real source.
module decode_read_sel
    import pipeline_defs::*;
(
    input  logic [4:0] opcode,
    input  logic [4:0] rd,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    output logic [4:0] ctrl_readRegA,
    output logic [4:0] ctrl_readRegB,
    output logic       use_a,
    output logic       use_b
);

    // Pick read addresses by instruction class; unused ports read $r0
    always_comb begin
        ctrl_readRegA = rs;
        ctrl_readRegB = REG_ZERO;
        use_a         = 1'b1;
        use_b         = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl_readRegB = rt;
                use_b         = 1'b1;
            end
            OP_SW, OP_BNE, OP_BLT: begin
                ctrl_readRegB = rd;
                use_b         = 1'b1;
            end
            OP_JR: begin
                ctrl_readRegA = rd;
            end
            OP_BEX: begin
                ctrl_readRegA = REG_RSTATUS;
            end
            OP_JAL, OP_SETX: begin
                ctrl_readRegA = rs;
            end
            default: begin
                ctrl_readRegA = rs;
            end
        endcase
    end

endmodule

// File: rtl/decode_read_stage.sv
// Decode/operand-read stage: drives regfile read ports, applies writeback
// write-through and $r0 forcing, inserts load-use bubbles, honours hold and
// flush, and registers the result into the D/X pipeline register.
// Optional macro DECODE_STALL_CNT_EN adds a saturating load-use stall counter.
module decode_read_stage
    import pipeline_defs::*;
#(
    parameter int          DATA_W   = 32,
    parameter logic [31:0] NOP_INSN = 32'h0000_0000,
    parameter int          CNT_W    = 16
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       fd_insn,
    input  logic [DATA_W-1:0] fd_pc,
    input  logic              fd_valid,
    output logic [4:0]        ctrl_readRegA,
    output logic [4:0]        ctrl_readRegB,
    input  logic [DATA_W-1:0] data_readRegA,
    input  logic [DATA_W-1:0] data_readRegB,
    input  logic              wb_writeEnable,
    input  logic [4:0]        wb_writeReg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              hold,
    input  logic              flush,
    output logic [31:0]       dx_insn,
    output logic [DATA_W-1:0] dx_pc,
    output logic [DATA_W-1:0] dx_a,
    output logic [DATA_W-1:0] dx_b,
    output logic              dx_valid,
`ifdef DECODE_STALL_CNT_EN
    output logic [CNT_W-1:0]  stall_count,
`endif
    output logic              stall_fd
);

    logic              use_a;
    logic              use_b;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [4:0]        dx_opcode;
    logic [4:0]        dx_rd;
    logic              load_use;
    logic              take_bubble;

    decode_read_sel u_sel (
        .opcode        (fd_insn[OPC_HI:OPC_LO]),
        .rd            (fd_insn[RD_HI:RD_LO]),
        .rs            (fd_insn[RS_HI:RS_LO]),
        .rt            (fd_insn[RT_HI:RT_LO]),
        .ctrl_readRegA (ctrl_readRegA),
        .ctrl_readRegB (ctrl_readRegB),
        .use_a         (use_a),
        .use_b         (use_b)
    );

    assign dx_opcode = dx_insn[OPC_HI:OPC_LO];
    assign dx_rd     = dx_insn[RD_HI:RD_LO];

    // Operand muxes: $r0 reads as zero, a same-cycle writeback wins over the regfile
    always_comb begin
        operand_a = data_readRegA;
        operand_b = data_readRegB;
        if (ctrl_readRegA == REG_ZERO) begin
            operand_a = '0;
        end else if (wb_writeEnable && (wb_writeReg == ctrl_readRegA)) begin
            operand_a = wb_data;
        end
        if (ctrl_readRegB == REG_ZERO) begin
            operand_b = '0;
        end else if (wb_writeEnable && (wb_writeReg == ctrl_readRegB)) begin
            operand_b = wb_data;
        end
    end

    // A lw in D/X whose destination is a real source of fd_insn cannot be bypassed yet
    always_comb begin
        load_use = 1'b0;
        if (fd_valid && dx_valid && (dx_opcode == OP_LW) && (dx_rd != REG_ZERO)) begin
            load_use = (use_a && (ctrl_readRegA == dx_rd)) ||
                       (use_b && (ctrl_readRegB == dx_rd));
        end
    end

    assign stall_fd    = hold || (!flush && load_use);
    assign take_bubble = flush || load_use || !fd_valid;

    // D/X register: hold freezes it, otherwise load a bubble or the decoded instruction
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dx_insn  <= NOP_INSN;
            dx_pc    <= '0;
            dx_a     <= '0;
            dx_b     <= '0;
            dx_valid <= 1'b0;
        end else if (!hold) begin
            if (take_bubble) begin
                dx_insn  <= NOP_INSN;
                dx_pc    <= '0;
                dx_a     <= '0;
                dx_b     <= '0;
                dx_valid <= 1'b0;
            end else begin
                dx_insn  <= fd_insn;
                dx_pc    <= fd_pc;
                dx_a     <= operand_a;
                dx_b     <= operand_b;
                dx_valid <= 1'b1;
            end
        end
    end

`ifdef DECODE_STALL_CNT_EN
    // Count inserted load-use bubbles, saturating at all-ones
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (!hold && !flush && load_use && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_decode_read_stage.sv
// Self-checking bench for decode_read_stage: directed scenarios followed by
// randomized traffic, compared against a behavioural model of the stage.
module tb_decode_read_stage;

    localparam int          DATA_W   = 32;
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;
    localparam int          CNT_W    = 16;

    logic              clock;
    logic              reset;
    logic [31:0]       fd_insn;
    logic [DATA_W-1:0] fd_pc;
    logic              fd_valid;
    logic [4:0]        ctrl_readRegA;
    logic [4:0]        ctrl_readRegB;
    logic [DATA_W-1:0] data_readRegA;
    logic [DATA_W-1:0] data_readRegB;
    logic              wb_writeEnable;
    logic [4:0]        wb_writeReg;
    logic [DATA_W-1:0] wb_data;
    logic              hold;
    logic              flush;
    logic [31:0]       dx_insn;
    logic [DATA_W-1:0] dx_pc;
    logic [DATA_W-1:0] dx_a;
    logic [DATA_W-1:0] dx_b;
    logic              dx_valid;
    logic              stall_fd;
`ifdef DECODE_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_count;
`endif

    decode_read_stage #(
        .DATA_W   (DATA_W),
        .NOP_INSN (NOP_INSN),
        .CNT_W    (CNT_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .fd_insn        (fd_insn),
        .fd_pc          (fd_pc),
        .fd_valid       (fd_valid),
        .ctrl_readRegA  (ctrl_readRegA),
        .ctrl_readRegB  (ctrl_readRegB),
        .data_readRegA  (data_readRegA),
        .data_readRegB  (data_readRegB),
        .wb_writeEnable (wb_writeEnable),
        .wb_writeReg    (wb_writeReg),
        .wb_data        (wb_data),
        .hold           (hold),
        .flush          (flush),
        .dx_insn        (dx_insn),
        .dx_pc          (dx_pc),
        .dx_a           (dx_a),
        .dx_b           (dx_b),
        .dx_valid       (dx_valid),
`ifdef DECODE_STALL_CNT_EN
        .stall_count    (stall_count),
`endif
        .stall_fd       (stall_fd)
    );

    // Register file environment: asynchronous read of whatever the stage addresses
    logic [DATA_W-1:0] rf [32];
    assign data_readRegA = rf[ctrl_readRegA];
    assign data_readRegB = rf[ctrl_readRegB];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model of the D/X register contents
    logic [31:0]       m_insn;
    logic [DATA_W-1:0] m_pc;
    logic [DATA_W-1:0] m_a;
    logic [DATA_W-1:0] m_b;
    logic              m_valid;
    int unsigned       m_cnt;
    bit                m_stall;

    int checkCount = 0;
    int errorCount = 0;

    logic [4:0] seen_a;
    logic [4:0] seen_b;
    logic       seen_stall;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] mkR(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rd, rs, rt, 12'h000};
    endfunction

    function automatic logic [31:0] mkI(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    // Which registers an instruction reads, straight from the ISA's operand table
    function automatic void sources(input logic [31:0] insn, output logic [4:0] a, output logic [4:0] b,
                                    output bit ua, output bit ub);
        logic [4:0] op;
        op = insn[31:27];
        a = insn[21:17];
        b = 5'd0;
        ua = 1'b1;
        ub = 1'b0;
        if (op == 5'b00000) begin
            b = insn[16:12];
            ub = 1'b1;
        end else if (op == 5'b00111 || op == 5'b00010 || op == 5'b00110) begin
            b = insn[26:22];
            ub = 1'b1;
        end else if (op == 5'b00100) begin
            a = insn[26:22];
        end else if (op == 5'b10110) begin
            a = 5'd30;
        end
    endfunction

    function automatic logic [DATA_W-1:0] readValue(input logic [4:0] addr, input logic we,
                                                    input logic [4:0] wr, input logic [DATA_W-1:0] wd);
        if (addr == 5'd0) return '0;
        if (we && wr == addr) return wd;
        return rf[addr];
    endfunction

    task automatic modelReset();
        m_insn  = NOP_INSN;
        m_pc    = '0;
        m_a     = '0;
        m_b     = '0;
        m_valid = 1'b0;
        m_cnt   = 0;
        m_stall = 1'b0;
    endtask

    // Drive one cycle of inputs, check the combinational outputs, clock, then check D/X
    task automatic applyStimulus(input logic [31:0] insn, input logic [DATA_W-1:0] pc, input logic valid,
                                 input logic we, input logic [4:0] wr, input logic [DATA_W-1:0] wd,
                                 input logic h, input logic f);
        logic [4:0] ea, eb;
        bit ua, ub, lu, exp_stall;
        logic [4:0] used[$];
        logic [31:0] n_insn;
        logic [DATA_W-1:0] n_pc, n_a, n_b;
        logic n_valid;

        fd_insn = insn; fd_pc = pc; fd_valid = valid;
        wb_writeEnable = we; wb_writeReg = wr; wb_data = wd;
        hold = h; flush = f;
        #1;

        sources(insn, ea, eb, ua, ub);
        if (ua && ea != 0) used.push_back(ea);
        if (ub && eb != 0) used.push_back(eb);
        lu = 1'b0;
        if (valid && m_valid && m_insn[31:27] == 5'b01000 && m_insn[26:22] != 0)
            foreach (used[i]) if (used[i] == m_insn[26:22]) lu = 1'b1;

        n_insn = m_insn; n_pc = m_pc; n_a = m_a; n_b = m_b; n_valid = m_valid;
        if (h) begin
            exp_stall = 1'b1;
        end else if (f || lu || !valid) begin
            exp_stall = lu && !f;
            n_insn = NOP_INSN; n_pc = '0; n_a = '0; n_b = '0; n_valid = 1'b0;
            if (lu && !f && m_cnt < (2**CNT_W - 1)) m_cnt++;
        end else begin
            exp_stall = 1'b0;
            n_insn = insn; n_pc = pc; n_valid = 1'b1;
            n_a = readValue(ea, we, wr, wd);
            n_b = readValue(eb, we, wr, wd);
        end

        seen_a = ctrl_readRegA;
        seen_b = ctrl_readRegB;
        seen_stall = stall_fd;
        checkOutput("ctrl_readRegA", 64'(ctrl_readRegA), 64'(ea));
        checkOutput("ctrl_readRegB", 64'(ctrl_readRegB), 64'(eb));
        checkOutput("stall_fd", 64'(stall_fd), 64'(exp_stall));

        @(posedge clock);
        #1;
        if (we && wr != 0) rf[wr] = wd;
        m_insn = n_insn; m_pc = n_pc; m_a = n_a; m_b = n_b; m_valid = n_valid;
        m_stall = exp_stall;

        checkOutput("dx_insn", 64'(dx_insn), 64'(m_insn));
        checkOutput("dx_pc", 64'(dx_pc), 64'(m_pc));
        checkOutput("dx_a", 64'(dx_a), 64'(m_a));
        checkOutput("dx_b", 64'(dx_b), 64'(m_b));
        checkOutput("dx_valid", 64'(dx_valid), 64'(m_valid));
`ifdef DECODE_STALL_CNT_EN
        checkOutput("stall_count", 64'(stall_count), 64'(m_cnt));
`endif
    endtask

    localparam logic [4:0] OPS [10] = '{5'b00000, 5'b01000, 5'b00111, 5'b00010, 5'b00110,
                                        5'b00100, 5'b10110, 5'b00011, 5'b10101, 5'b00101};

    initial begin
        logic [31:0] saved_insn;
        logic [DATA_W-1:0] saved_a;
        logic [31:0] r_insn;
        logic [DATA_W-1:0] r_pc;
        logic r_valid;

        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i * 3);
        rf[0] = 32'hDEAD_BEEF;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        fd_insn = '0; fd_pc = '0; fd_valid = 1'b0;
        wb_writeEnable = 1'b0; wb_writeReg = '0; wb_data = '0;
        hold = 1'b0; flush = 1'b0;
        reset = 1'b1;
        modelReset();
        #3;
        checkOutput("reset_dx_insn", 64'(dx_insn), 64'(NOP_INSN));
        checkOutput("reset_dx_valid", 64'(dx_valid), 64'd0);
        checkOutput("reset_dx_a", 64'(dx_a), 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // add $3,$1,$2 reads r1/r2
        applyStimulus(mkR(5'b00000, 5'd3, 5'd1, 5'd2), 32'h11, 1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b0);
        checkOutput("add_readA", 64'(seen_a), 64'd1);
        checkOutput("add_readB", 64'(seen_b), 64'd2);
        checkOutput("add_dx_a", 64'(dx_a), 64'd5);
        checkOutput("add_dx_b", 64'(dx_b), 64'd7);

        // Write-through of r1, then a write to r0 must not leak into a $0 read
        applyStimulus(mkR(5'b00000, 5'd3, 5'd1, 5'd2), 32'h12, 1'b1, 1'b1, 5'd1, 32'h99, 1'b0, 1'b0);
        checkOutput("bypass_dx_a", 64'(dx_a), 64'h99);
        applyStimulus(mkR(5'b00000, 5'd3, 5'd0, 5'd2), 32'h13, 1'b1, 1'b1, 5'd0, 32'h55, 1'b0, 1'b0);
        checkOutput("r0_dx_a", 64'(dx_a), 64'd0);

        // Load-use: lw $4,0($1) then add $5,$4,$1 stalls once
        applyStimulus(mkI(5'b01000, 5'd4, 5'd1, 17'd0), 32'h20, 1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b0);
        applyStimulus(mkR(5'b00000, 5'd5, 5'd4, 5'd1), 32'h21, 1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b0);
        checkOutput("lu_stall", 64'(seen_stall), 64'd1);
        checkOutput("lu_bubble_valid", 64'(dx_valid), 64'd0);
        applyStimulus(mkR(5'b00000, 5'd5, 5'd4, 5'd1), 32'h21, 1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b0);
        checkOutput("lu_retry_valid", 64'(dx_valid), 64'd1);
        applyStimulus(mkI(5'b01000, 5'd4, 5'd1, 17'd0), 32'h22, 1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b0);
        applyStimulus(mkR(5'b00000, 5'd5, 5'd6, 5'd1), 32'h23, 1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b0);
        checkOutput("nolu_stall", 64'(seen_stall), 64'd0);

        // Hold for 3 cycles with flush in the middle, then flush alone
        saved_insn = dx_insn;
        saved_a = dx_a;
        applyStimulus(mkR(5'b00000, 5'd9, 5'd2, 5'd2), 32'h30, 1'b1, 1'b0, 5'd0, '0, 1'b1, 1'b0);
        applyStimulus(mkR(5'b00000, 5'd9, 5'd2, 5'd2), 32'h30, 1'b1, 1'b0, 5'd0, '0, 1'b1, 1'b1);
        checkOutput("hold_flush_stall", 64'(seen_stall), 64'd1);
        applyStimulus(mkR(5'b00000, 5'd9, 5'd2, 5'd2), 32'h30, 1'b1, 1'b0, 5'd0, '0, 1'b1, 1'b0);
        checkOutput("hold_keep_insn", 64'(dx_insn), 64'(saved_insn));
        checkOutput("hold_keep_a", 64'(dx_a), 64'(saved_a));
        applyStimulus(mkR(5'b00000, 5'd9, 5'd2, 5'd2), 32'h30, 1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b1);
        checkOutput("flush_valid", 64'(dx_valid), 64'd0);

        // Special read-address cases
        applyStimulus({5'b10110, 27'd0}, 32'h40, 1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b0);
        checkOutput("bex_readA", 64'(seen_a), 64'd30);
        applyStimulus(mkI(5'b00111, 5'd7, 5'd2, 17'd4), 32'h41, 1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b0);
        checkOutput("sw_readA", 64'(seen_a), 64'd2);
        checkOutput("sw_readB", 64'(seen_b), 64'd7);
        applyStimulus({5'b00100, 5'd31, 22'd0}, 32'h42, 1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b0);
        checkOutput("jr_readA", 64'(seen_a), 64'd31);

        // Asynchronous reset between edges
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_dx_insn", 64'(dx_insn), 64'(NOP_INSN));
        checkOutput("async_dx_a", 64'(dx_a), 64'd0);
        checkOutput("async_dx_valid", 64'(dx_valid), 64'd0);
        modelReset();
        @(negedge clock);
        reset = 1'b0;

        // Randomized traffic; a stalled or held instruction is re-presented
        r_insn = '0; r_pc = '0; r_valid = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!m_stall || n == 0) begin
                r_insn = {OPS[$urandom_range(0, 9)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 12'($urandom)};
                if ($urandom_range(0, 15) == 0) r_insn[26:22] = 5'd31;
                r_pc = $urandom;
                r_valid = ($urandom_range(0, 7) != 0);
            end
            applyStimulus(r_insn, r_pc, r_valid, ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                          $urandom, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
